// File: rtl/mem_wb_stage_if.sv
// ============================================================================
// Module      : mem_wb_stage_if
// Description : MEM-to-WB pipeline bus, MEM-side inputs plus WB-side outputs.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface mem_wb_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_AW     = 5
);
   logic                  data_memory_busywait;
   logic                  valid_in;
   logic                  mem_read_signal;
   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] alu_out_mem;
   logic                  reg_write_en_in;
   logic [REG_AW-1:0]     reg_write_address_in;

   logic                  reg_write_en_wb;
   logic [REG_AW-1:0]     reg_write_address_wb;
   logic [DATA_WIDTH-1:0] data_wb;
   logic                  mem_read_en_WB;
   logic [REG_AW-1:0]     mem_address_WB;

   modport master (
      output data_memory_busywait, valid_in, mem_read_signal, load_data,
             alu_out_mem, reg_write_en_in, reg_write_address_in,
      input  reg_write_en_wb, reg_write_address_wb, data_wb,
             mem_read_en_WB, mem_address_WB
   );

   modport slave (
      input  data_memory_busywait, valid_in, mem_read_signal, load_data,
             alu_out_mem, reg_write_en_in, reg_write_address_in,
      output reg_write_en_wb, reg_write_address_wb, data_wb,
             mem_read_en_WB, mem_address_WB
   );
endinterface

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register with cache-stall performance counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_AW     = 5,
   parameter int CNT_WIDTH  = 32
) (
   input  wire logic                 clock,
   input  wire logic                 reset,
   mem_wb_stage_if.slave             mem_wb,
   input  wire logic [1:0]           perf_sel,
   input  wire logic                 perf_clear,
   output logic      [CNT_WIDTH-1:0] perf_count
);

   localparam logic [0:0]           c_st_run   = 1'b0;
   localparam logic [0:0]           c_st_stall = 1'b1;
   localparam logic [CNT_WIDTH-1:0] c_cnt_max  = '1;
   localparam logic [CNT_WIDTH-1:0] c_cnt_one  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic                 w_busy;
   logic                 w_retire;
   logic [0:0]           r_state;
   logic [0:0]           w_state_nxt;
   logic                 w_enter_stall;
   logic                 w_leave_stall;

   logic [CNT_WIDTH-1:0] r_retired;
   logic [CNT_WIDTH-1:0] r_stall_cyc;
   logic [CNT_WIDTH-1:0] r_episodes;
   logic [CNT_WIDTH-1:0] r_longest;
   logic [CNT_WIDTH-1:0] r_cur_len;

   function automatic logic [CNT_WIDTH-1:0] f_sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == c_cnt_max) ? v : v + c_cnt_one;
   endfunction

   assign w_busy   = mem_wb.data_memory_busywait;
   assign w_retire = ~w_busy & mem_wb.valid_in;

   // Stall FSM: state register, next state, outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= c_st_run;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_run:   if (w_busy)  w_state_nxt = c_st_stall;
         c_st_stall: if (!w_busy) w_state_nxt = c_st_run;
         default:    w_state_nxt = c_st_run;
      endcase
   end

   always_comb begin
      w_enter_stall = 1'b0;
      w_leave_stall = 1'b0;
      case (r_state)
         c_st_run:   w_enter_stall = w_busy;
         c_st_stall: w_leave_stall = ~w_busy;
         default:    ;
      endcase
   end

   // WB registers freeze during a stall so the store-forward source stays stable.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem_wb.data_wb              <= '0;
         mem_wb.reg_write_en_wb      <= 1'b0;
         mem_wb.reg_write_address_wb <= '0;
         mem_wb.mem_read_en_WB       <= 1'b0;
         mem_wb.mem_address_WB       <= '0;
      end else if (!w_busy) begin
         mem_wb.data_wb              <= mem_wb.mem_read_signal ? mem_wb.load_data
                                                               : mem_wb.alu_out_mem;
         mem_wb.reg_write_en_wb      <= mem_wb.reg_write_en_in & mem_wb.valid_in;
         mem_wb.reg_write_address_wb <= mem_wb.reg_write_address_in;
         mem_wb.mem_read_en_WB       <= mem_wb.mem_read_signal & mem_wb.valid_in;
         mem_wb.mem_address_WB       <= mem_wb.reg_write_address_in;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_retired   <= '0;
         r_stall_cyc <= '0;
         r_episodes  <= '0;
         r_longest   <= '0;
         r_cur_len   <= '0;
      end else if (perf_clear) begin
         r_retired   <= '0;
         r_stall_cyc <= '0;
         r_episodes  <= '0;
         r_longest   <= '0;
         r_cur_len   <= '0;
      end else begin
         if (w_retire) begin
            r_retired <= f_sat_inc(r_retired);
         end
         if (w_busy) begin
            r_stall_cyc <= f_sat_inc(r_stall_cyc);
            r_cur_len   <= f_sat_inc(r_cur_len);
         end
         if (w_enter_stall) begin
            r_episodes <= f_sat_inc(r_episodes);
         end
         // The episode length only folds into the maximum once it has ended.
         if (w_leave_stall) begin
            r_longest <= (r_cur_len > r_longest) ? r_cur_len : r_longest;
            r_cur_len <= '0;
         end
      end
   end

   always_comb begin
      perf_count = r_retired;
      case (perf_sel)
         2'd0:    perf_count = r_retired;
         2'd1:    perf_count = r_stall_cyc;
         2'd2:    perf_count = r_episodes;
         2'd3:    perf_count = r_longest;
         default: perf_count = r_retired;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Directed bench for mem_wb_stage, checked against a behavioural model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int CW  = 32;
   localparam int CWS = 3;
   localparam logic [63:0] MAX_MAIN  = 64'hFFFF_FFFF;
   localparam logic [63:0] MAX_SMALL = 64'd7;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic          busy = 1'b0, valid = 1'b0, mrs = 1'b0, we_in = 1'b0, clr = 1'b0;
   logic [DW-1:0] ld = '0, alu = '0;
   logic [AW-1:0] rd = '0;
   logic [1:0]    perf_sel = 2'd0;
   logic [CW-1:0]  perf_count;
   logic [CWS-1:0] perf_count_s;

   int n_cmp = 0;
   int n_err = 0;

   mem_wb_stage_if #(.DATA_WIDTH(DW), .REG_AW(AW)) wb  ();
   mem_wb_stage_if #(.DATA_WIDTH(DW), .REG_AW(AW)) wbs ();

   assign wb.data_memory_busywait  = busy;
   assign wb.valid_in              = valid;
   assign wb.mem_read_signal       = mrs;
   assign wb.load_data             = ld;
   assign wb.alu_out_mem           = alu;
   assign wb.reg_write_en_in       = we_in;
   assign wb.reg_write_address_in  = rd;
   assign wbs.data_memory_busywait = busy;
   assign wbs.valid_in             = valid;
   assign wbs.mem_read_signal      = mrs;
   assign wbs.load_data            = ld;
   assign wbs.alu_out_mem          = alu;
   assign wbs.reg_write_en_in      = we_in;
   assign wbs.reg_write_address_in = rd;

   mem_wb_stage #(.DATA_WIDTH(DW), .REG_AW(AW), .CNT_WIDTH(CW)) dut (
      .clock      (clock),
      .reset      (reset),
      .mem_wb     (wb.slave),
      .perf_sel   (perf_sel),
      .perf_clear (clr),
      .perf_count (perf_count)
   );

   // Narrow counters so saturation is reached within a short run.
   mem_wb_stage #(.DATA_WIDTH(DW), .REG_AW(AW), .CNT_WIDTH(CWS)) dut_s (
      .clock      (clock),
      .reset      (reset),
      .mem_wb     (wbs.slave),
      .perf_sel   (perf_sel),
      .perf_clear (clr),
      .perf_count (perf_count_s)
   );

   // Behavioural model: true event counts, saturation applied at compare time.
   logic [DW-1:0] m_data = '0;
   logic          m_we = 1'b0, m_mr = 1'b0, m_prev_busy = 1'b0;
   logic [AW-1:0] m_wa = '0, m_ma = '0;
   logic [63:0]   m_ret = '0, m_stall = '0, m_epi = '0, m_long = '0, m_run = '0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_data <= '0; m_we <= 1'b0; m_mr <= 1'b0; m_wa <= '0; m_ma <= '0;
         m_ret <= '0; m_stall <= '0; m_epi <= '0; m_long <= '0; m_run <= '0;
         m_prev_busy <= 1'b0;
      end else begin
         if (!busy) begin
            m_data <= mrs ? ld : alu;
            m_we   <= we_in & valid;
            m_mr   <= mrs & valid;
            m_wa   <= rd;
            m_ma   <= rd;
         end
         if (clr) begin
            m_ret <= '0; m_stall <= '0; m_epi <= '0; m_long <= '0; m_run <= '0;
         end else begin
            if (!busy && valid) m_ret <= m_ret + 64'd1;
            if (busy) begin
               m_stall <= m_stall + 64'd1;
               m_run   <= m_run + 64'd1;
               if (!m_prev_busy) m_epi <= m_epi + 64'd1;
            end else if (m_prev_busy) begin
               m_long <= (m_run > m_long) ? m_run : m_long;
               m_run  <= '0;
            end
         end
         m_prev_busy <= busy;
      end
   end

   function automatic logic [63:0] model_cnt(input int s, input logic [63:0] lim);
      logic [63:0] v;
      case (s)
         0:       v = m_ret;
         1:       v = m_stall;
         2:       v = m_epi;
         default: v = m_long;
      endcase
      return (v > lim) ? lim : v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always begin
      @(negedge clock);
      chk("data_wb",    64'(wb.data_wb),              64'(m_data));
      chk("we_wb",      64'(wb.reg_write_en_wb),      64'(m_we));
      chk("waddr_wb",   64'(wb.reg_write_address_wb), 64'(m_wa));
      chk("mrd_wb",     64'(wb.mem_read_en_WB),       64'(m_mr));
      chk("maddr_wb",   64'(wb.mem_address_WB),       64'(m_ma));
      chk("data_wb_s",  64'(wbs.data_wb),             64'(m_data));
      for (int s = 0; s < 4; s++) begin
         perf_sel = s[1:0];
         #1;
         chk("perf_count",   64'(perf_count),   model_cnt(s, MAX_MAIN));
         chk("perf_count_s", 64'(perf_count_s), model_cnt(s, MAX_SMALL));
      end
   end

   task automatic cyc(input logic b, input logic v, input logic m, input logic w,
                      input logic c, input logic [DW-1:0] l, input logic [DW-1:0] a,
                      input logic [AW-1:0] r);
      busy = b; valid = v; mrs = m; we_in = w; clr = c; ld = l; alu = a; rd = r;
      @(posedge clock);
      #1;
   endtask

   task automatic chk_wb(input string nm, input logic [DW-1:0] d, input logic we,
                         input logic [AW-1:0] wa, input logic mr);
      chk({nm, ".data"}, 64'(wb.data_wb),              64'(d));
      chk({nm, ".we"},   64'(wb.reg_write_en_wb),      64'(we));
      chk({nm, ".wa"},   64'(wb.reg_write_address_wb), 64'(wa));
      chk({nm, ".mr"},   64'(wb.mem_read_en_WB),       64'(mr));
      chk({nm, ".ma"},   64'(wb.mem_address_WB),       64'(wa));
   endtask

   task automatic chk_cnt(input string nm, input logic [63:0] ret, input logic [63:0] stl,
                          input logic [63:0] epi, input logic [63:0] lng);
      chk({nm, ".retired"},  m_ret,   ret);
      chk({nm, ".stall"},    m_stall, stl);
      chk({nm, ".episodes"}, m_epi,   epi);
      chk({nm, ".longest"},  m_long,  lng);
   endtask

   initial begin
      #1 reset = 1'b0;
      #1 chk_wb("reset", 32'h0, 1'b0, 5'd0, 1'b0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;

      // ALU op
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hAAAA5555, 32'h12, 5'd5);
      chk_wb("alu", 32'h12, 1'b1, 5'd5, 1'b0);

      // Load, then a 4-cycle stall with changing MEM inputs
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h99, 5'd7);
      chk_wb("load", 32'hDEADBEEF, 1'b1, 5'd7, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h11111111 + 32'(i), 32'h22, 5'd3);
         chk_wb("hold", 32'hDEADBEEF, 1'b1, 5'd7, 1'b1);
      end
      // Stall ends on a bubble: enables clear, data still captured
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33, 32'h44, 5'd9);
      chk_wb("bubble", 32'h44, 1'b0, 5'd9, 1'b0);
      chk_cnt("stall4", 64'd2, 64'd4, 64'd1, 64'd4);

      // Stalls of 2 and 6 separated by one free cycle
      for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h50, 5'd1);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h55, 5'd1);
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h60, 5'd2);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h66, 5'd2);
      chk_cnt("two_eps", 64'd4, 64'd12, 64'd3, 64'd6);

      // Clear on the same edge as a retire
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h77, 5'd4);
      chk_cnt("clear", 64'd0, 64'd0, 64'd0, 64'd0);
      chk("clear.data", 64'(wb.data_wb), 64'h77);

      // Single-cycle stall
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h78, 5'd4);
      chk_cnt("single", 64'd1, 64'd1, 64'd1, 64'd1);

      // Clear in the middle of a stall
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 5'd0);
      clr = 1'b0;
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h79, 5'd6);
      chk_cnt("clr_stall", 64'd0, 64'd1, 64'd0, 64'd1);

      // Back-to-back misses, busywait never drops
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100 + 32'(i), 32'h0, 5'(i));
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h7A, 5'd6);
      chk_cnt("b2b", 64'd0, 64'd4, 64'd1, 64'd3);

      // Drive the narrow instance into saturation
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'(i), 5'(i));
      for (int i = 0; i < 9; i++)  cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h7B, 5'd8);
      chk_cnt("sat", 64'd10, 64'd13, 64'd2, 64'd9);

      // Reset during the third cycle of a stall, released with busywait high
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd0);
      reset = 1'b0;
      #1 chk_wb("rst_stall", 32'h0, 1'b0, 5'd0, 1'b0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      chk_cnt("post_rst", 64'd0, 64'd1, 64'd1, 64'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      chk_cnt("post_rst_end", 64'd0, 64'd1, 64'd1, 64'd1);

      @(negedge clock);
      #5;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
